// File: rtl/nvdla_csb_pkg.sv
// Shared types and helpers for the APB-to-CSB bridge.
// Holds the FSM state encoding, data widths, window decode and error-count saturation.
package nvdla_csb_pkg;

    localparam int CSB_DW    = 32;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RD,
        WAIT_WR,
        DONE
    } state_e;

    // Address is zero-extended by the caller so one function serves any APB_AW.
    function automatic logic win_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] mask);
        return (addr & mask) == base;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == {ERR_CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/nvdla_csb_tmo.sv
// Response timeout counter: cleared while not waiting, counts wait cycles,
// and flags expiry on the cycle the count would reach all-ones.
module nvdla_csb_tmo #(
    parameter int TMO_W = 12
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign o_expire  = i_en && (w_cnt_nxt == {TMO_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/nvdla_apb2csb_ext.sv
// APB-to-CSB bridge: one APB access at a time, window decode, optional non-posted
// writes, response timeout with stale-response drop, and a saturating error count.
module nvdla_apb2csb_ext
    import nvdla_csb_pkg::*;
#(
    parameter int          APB_AW     = 32,
    parameter int          CSB_AW     = 16,
    parameter logic [31:0] WIN_BASE   = 32'h0000_0000,
    parameter logic [31:0] WIN_MASK   = 32'hFFFC_0000,
    parameter bit          NPOSTED_WR = 1'b0,
    parameter int          TMO_W      = 12
) (
    input  logic                 csb_clk,
    input  logic                 csb_rst,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [APB_AW-1:0]    paddr,
    input  logic [CSB_DW-1:0]    pwdata,
    output logic [CSB_DW-1:0]    prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic                 csb2nvdla_valid,
    input  logic                 csb2nvdla_ready,
    output logic [CSB_AW-1:0]    csb2nvdla_addr,
    output logic [CSB_DW-1:0]    csb2nvdla_wdat,
    output logic                 csb2nvdla_write,
    output logic                 csb2nvdla_nposted,
    input  logic                 nvdla2csb_valid,
    input  logic [CSB_DW-1:0]    nvdla2csb_data,
    input  logic                 nvdla2csb_wr_complete,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_e               r_state;
    logic                 r_valid;
    logic                 r_write;
    logic                 r_nposted;
    logic                 r_pready;
    logic                 r_pslverr;
    logic                 r_stale_rd;
    logic                 r_stale_wr;
    logic [CSB_AW-1:0]    r_addr;
    logic [CSB_DW-1:0]    r_wdat;
    logic [CSB_DW-1:0]    r_prdata;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic w_hit;
    logic w_waiting;
    logic w_expire;
    logic w_rd_take;
    logic w_wr_take;

    assign w_hit     = win_hit(64'(paddr), 64'(WIN_BASE), 64'(WIN_MASK));
    assign w_waiting = (r_state == WAIT_RD) || (r_state == WAIT_WR);
    // A response owed to a timed-out access is never delivered to the current one.
    assign w_rd_take = nvdla2csb_valid && !r_stale_rd;
    assign w_wr_take = nvdla2csb_wr_complete && !r_stale_wr;

    nvdla_csb_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .i_clk    (csb_clk),
        .i_rst    (csb_rst),
        .i_clr    (!w_waiting),
        .i_en     (w_waiting),
        .o_expire (w_expire)
    );

    always_ff @(posedge csb_clk) begin
        if (csb_rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_write    <= 1'b0;
            r_nposted  <= 1'b0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_stale_rd <= 1'b0;
            r_stale_wr <= 1'b0;
            r_addr     <= '0;
            r_wdat     <= '0;
            r_prdata   <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            if (nvdla2csb_valid && r_stale_rd)       r_stale_rd <= 1'b0;
            if (nvdla2csb_wr_complete && r_stale_wr) r_stale_wr <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (psel && penable) begin
                        r_write   <= pwrite;
                        r_addr    <= paddr[CSB_AW+1:2];
                        r_wdat    <= pwdata;
                        r_nposted <= pwrite & NPOSTED_WR;
                        if (!w_hit) begin
                            r_state   <= DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= 1'b1;
                            r_prdata  <= '0;
                            r_err_cnt <= err_inc(r_err_cnt);
                        end else begin
                            r_state <= REQ;
                            r_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (csb2nvdla_ready) begin
                        r_valid <= 1'b0;
                        if (!r_write) begin
                            r_state <= WAIT_RD;
                        end else if (r_nposted) begin
                            r_state <= WAIT_WR;
                        end else begin
                            r_state  <= DONE;
                            r_pready <= 1'b1;
                        end
                    end
                end
                WAIT_RD: begin
                    if (w_rd_take) begin
                        r_state  <= DONE;
                        r_pready <= 1'b1;
                        r_prdata <= nvdla2csb_data;
                    end else if (w_expire) begin
                        r_state    <= DONE;
                        r_pready   <= 1'b1;
                        r_pslverr  <= 1'b1;
                        r_prdata   <= '0;
                        r_stale_rd <= 1'b1;
                        r_err_cnt  <= err_inc(r_err_cnt);
                    end
                end
                WAIT_WR: begin
                    if (w_wr_take) begin
                        r_state  <= DONE;
                        r_pready <= 1'b1;
                    end else if (w_expire) begin
                        r_state    <= DONE;
                        r_pready   <= 1'b1;
                        r_pslverr  <= 1'b1;
                        r_prdata   <= '0;
                        r_stale_wr <= 1'b1;
                        r_err_cnt  <= err_inc(r_err_cnt);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign prdata            = r_prdata;
    assign pready            = r_pready;
    assign pslverr           = r_pslverr;
    assign csb2nvdla_valid   = r_valid;
    assign csb2nvdla_addr    = r_addr;
    assign csb2nvdla_wdat    = r_wdat;
    assign csb2nvdla_write   = r_write;
    assign csb2nvdla_nposted = r_nposted;
    assign err_cnt           = r_err_cnt;

endmodule
